// File: rtl/axi_slave_write_resp.sv
// axi_slave_write_resp: AXI slave write responder. Accepts one write address,
// consumes exactly AWLEN+1 data beats, forwards each beat to a backend memory
// port with its computed byte address, and returns one response per burst.
// Optional feature: define AXI_SLV_WID_CHECK_EN to flag beats whose WID
// differs from the latched AWID as SLVERR (write suppressed from that beat on).
module axi_slave_write_resp #(
  parameter int addr_width   = 32,
  parameter int data_width   = 64,
  parameter int strobe_width = data_width / 8
) (
  input  logic                    AClk,
  input  logic                    ARst,
  input  logic [7:0]              AWID,
  input  logic [addr_width-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [7:0]              WID,
  input  logic [data_width-1:0]   WDATA,
  input  logic [strobe_width-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [7:0]              BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_we,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_wdata,
  output logic [strobe_width-1:0] mem_wstrb,
  input  logic                    mem_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  localparam logic [31:0] STRB_W = strobe_width;

  state_t                  state_q, state_d;
  logic [7:0]              id_q, id_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    err_q, err_d;
  logic                    awready_q, awready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  logic [7:0]              aw_bytes_s;
  logic                    wrap_len_ok_s;
  logic                    dec_err_s;
  logic [addr_width-1:0]   one_s, bytes_s, span_s, lower_s, aligned_s, inc_s;
  logic [addr_width-1:0]   next_addr_s;
  logic                    wlast_err_s, wid_err_s, beat_err_s, w_hs_s;

  // Address-phase decode: illegal burst type, bad WRAP length, beat wider than the bus.
  assign aw_bytes_s    = 8'd1 << AWSIZE;
  assign wrap_len_ok_s = (AWLEN == 8'd1) || (AWLEN == 8'd3) || (AWLEN == 8'd7) || (AWLEN == 8'd15);
  assign dec_err_s     = (AWBURST == 2'b11) ||
                         ((AWBURST == 2'b10) && !wrap_len_ok_s) ||
                         ({24'd0, aw_bytes_s} > STRB_W);

  // Next beat address from the latched burst parameters; span is a power of two for legal WRAP.
  assign one_s     = {{(addr_width-1){1'b0}}, 1'b1};
  assign bytes_s   = one_s << size_q;
  assign span_s    = ({{(addr_width-8){1'b0}}, len_q} + one_s) << size_q;
  assign lower_s   = addr_q & ~(span_s - one_s);
  assign aligned_s = addr_q & ~(bytes_s - one_s);
  assign inc_s     = aligned_s + bytes_s;

  // Select the following beat address by burst type.
  always_comb begin
    next_addr_s = addr_q;
    case (burst_q)
      2'b00:   next_addr_s = addr_q;
      2'b01:   next_addr_s = inc_s;
      2'b10:   next_addr_s = (inc_s == (lower_s + span_s)) ? lower_s : inc_s;
      default: next_addr_s = addr_q;
    endcase
  end

  // Per-beat protocol errors: WLAST must mark exactly the final counted beat.
  assign wlast_err_s = (WLAST != (cnt_q == 8'd0));
`ifdef AXI_SLV_WID_CHECK_EN
  assign wid_err_s   = (WID != id_q);
`else
  logic unused_wid_s;
  assign unused_wid_s = ^WID;
  assign wid_err_s    = 1'b0;
`endif
  assign beat_err_s  = wlast_err_s | wid_err_s;

  // W channel and backend port are combinational so a beat lands the cycle it is accepted.
  assign WREADY    = (state_q == DATA) && mem_ready;
  assign w_hs_s    = WREADY && WVALID;
  assign mem_we    = w_hs_s && !err_q && !beat_err_s;
  assign mem_addr  = addr_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

  assign AWREADY = awready_q;
  assign BVALID  = bvalid_q;
  assign BID     = id_q;
  assign BRESP   = bresp_q;

  // Next-state logic: IDLE takes an address, DATA counts beats, RESP waits for BREADY.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    bresp_d = bresp_q;
    case (state_q)
      IDLE: begin
        if (AWVALID && awready_q) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          cnt_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          err_d   = dec_err_s;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (w_hs_s) begin
          addr_d = next_addr_s;
          err_d  = err_q | beat_err_s;
          if (cnt_q == 8'd0) begin
            state_d = RESP;
            bresp_d = (err_q | beat_err_s) ? 2'b10 : 2'b00;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (BREADY) begin
          state_d = IDLE;
          err_d   = 1'b0;
          bresp_d = 2'b00;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    bvalid_d  = (state_d == RESP);
  end

  // State and handshake registers; reset drops any partial transaction.
  always_ff @(posedge AClk or negedge ARst) begin
    if (!ARst) begin
      state_q   <= IDLE;
      id_q      <= 8'd0;
      addr_q    <= {addr_width{1'b0}};
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_write_resp.sv
// Bench for axi_slave_write_resp: directed vector table, hand-written corner
// sequences (WLAST error, BREADY stall, mid-burst reset, WID mismatch) and
// randomized bursts checked against a closed-form address/response model.
module tb_axi_slave_write_resp;
  localparam int SW = 8;

  logic        AClk = 1'b0;
  logic        ARst = 1'b0;
  logic [7:0]  AWID = 8'd0;
  logic [31:0] AWADDR = 32'd0;
  logic [7:0]  AWLEN = 8'd0;
  logic [2:0]  AWSIZE = 3'd0;
  logic [1:0]  AWBURST = 2'd0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [7:0]  WID = 8'd0;
  logic [63:0] WDATA = 64'd0;
  logic [7:0]  WSTRB = 8'd0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready = 1'b1;

  always #5 AClk = ~AClk;

  axi_slave_write_resp dut (
    .AClk(AClk), .ARst(ARst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr[$];
  logic        obs_we[$];
  logic [1:0]  obs_resp;
  logic [7:0]  obs_bid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (closed form) ----------------
  function automatic logic model_dec_err(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok) || ((32'd1 << size) > 32'(SW));
  endfunction

  function automatic logic [31:0] model_addr(input logic [1:0] burst, input logic [31:0] addr,
                                             input logic [7:0] len, input logic [2:0] size, input int i);
    logic [31:0] bytes, aligned, span, lower, off;
    bytes   = 32'd1 << size;
    aligned = addr & ~(bytes - 32'd1);
    span    = bytes * (32'(len) + 32'd1);
    lower   = addr & ~(span - 32'd1);
    if (i == 0 || burst == 2'b00) return addr;
    if (burst == 2'b01) return aligned + 32'(i) * bytes;
    off = (aligned - lower) + 32'(i) * bytes;
    return lower + (off % span);
  endfunction

  // ---------------- one transaction driver ----------------
  task automatic do_txn(input logic [1:0] burst, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [7:0] id, input logic [7:0] wid,
                        input int bad_last, input int rdy_mode, input int bready_wait, input int rst_beat);
    int  beat;
    int  cyc;
    bit  done;
    obs_addr.delete();
    obs_we.delete();
    obs_resp = 2'bxx;
    obs_bid  = 8'hxx;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge AClk);
      done = AWREADY;
      @(posedge AClk); #1;
      cyc++;
    end
    AWVALID = 1'b0;
    chk("aw_handshake", 64'(done), 64'd1);
    if (!done) return;

    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 400) begin
      WVALID = 1'b1;
      WID    = wid;
      WDATA  = {$urandom(), $urandom()};
      WSTRB  = 8'($urandom());
      WLAST  = (beat == int'(len)) ^ (beat == bad_last);
      if (rdy_mode == 0) mem_ready = 1'b1;
      else if (rdy_mode == 1) mem_ready = (cyc % 2 == 0);
      else mem_ready = 1'($urandom_range(0, 1));
      if (beat == rst_beat) begin
        ARst = 1'b0;
        #1;
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_bid", 64'(BID), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge AClk); #1;
        ARst = 1'b1; WVALID = 1'b0; WLAST = 1'b0; mem_ready = 1'b1;
        return;
      end
      @(negedge AClk);
      if (cyc == 0) chk("awready_low_in_data", 64'(AWREADY), 64'd0);
      chk("bvalid_low_in_data", 64'(BVALID), 64'd0);
      chk("wready_vs_mem_ready", 64'(WREADY), 64'(mem_ready));
      if (WREADY) begin
        obs_addr.push_back(mem_addr);
        obs_we.push_back(mem_we);
        chk("mem_wdata", mem_wdata, WDATA);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(WSTRB));
        beat++;
      end else begin
        chk("mem_we_stalled", 64'(mem_we), 64'd0);
      end
      @(posedge AClk); #1;
      cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0; mem_ready = 1'b1;
    chk("w_beats_done", 64'(beat), 64'(int'(len) + 1));
    if (beat <= int'(len)) return;

    @(negedge AClk);
    chk("bvalid_after_last", 64'(BVALID), 64'd1);
    for (int k = 0; k < bready_wait; k++) begin
      @(posedge AClk); #1;
      @(negedge AClk);
      chk("bvalid_held", 64'(BVALID), 64'd1);
      chk("awready_low_in_resp", 64'(AWREADY), 64'd0);
    end
    @(posedge AClk); #1;
    BREADY = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge AClk);
      if (BVALID) begin
        done = 1'b1;
        obs_resp = BRESP;
        obs_bid  = BID;
      end
      @(posedge AClk); #1;
      cyc++;
    end
    BREADY = 1'b0;
    chk("b_handshake", 64'(done), 64'd1);
    @(negedge AClk);
    chk("bvalid_drop", 64'(BVALID), 64'd0);
    chk("awready_back", 64'(AWREADY), 64'd1);
    @(posedge AClk); #1;
  endtask

  typedef struct {
    logic [1:0]       burst;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    int               rdy_mode;
    logic [3:0][31:0] exp_addr;
    logic             exp_we;
    logic [1:0]       exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0]  r_burst;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [7:0]  r_id;
    int          r_bad;
    logic        r_dec;
    int          wrap_lens[4];
    bit          wid_err;

    wrap_lens = '{1, 3, 7, 15};
    vecs[0] = '{2'b01, 32'h100, 8'd3, 3'd3, 0, {32'h118, 32'h110, 32'h108, 32'h100}, 1'b1, 2'b00};
    vecs[1] = '{2'b10, 32'h38,  8'd3, 3'd3, 0, {32'h30, 32'h28, 32'h20, 32'h38}, 1'b1, 2'b00};
    vecs[2] = '{2'b00, 32'h1234, 8'd2, 3'd2, 1, {32'h0, 32'h1234, 32'h1234, 32'h1234}, 1'b1, 2'b00};
    vecs[3] = '{2'b11, 32'h40,  8'd1, 3'd3, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 2'b10};
    vecs[4] = '{2'b10, 32'h40,  8'd2, 3'd3, 1, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 2'b10};
    vecs[5] = '{2'b01, 32'h80,  8'd1, 3'd4, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 2'b10};
    vecs[6] = '{2'b01, 32'h103, 8'd2, 3'd2, 0, {32'h0, 32'h108, 32'h104, 32'h103}, 1'b1, 2'b00};
    vecs[7] = '{2'b01, 32'hFFFF_FFF8, 8'd1, 3'd3, 0, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8}, 1'b1, 2'b00};

    // Reset state and first AWREADY edge.
    ARst = 1'b0;
    repeat (2) @(negedge AClk);
    chk("reset_awready", 64'(AWREADY), 64'd0);
    chk("reset_wready", 64'(WREADY), 64'd0);
    chk("reset_bvalid", 64'(BVALID), 64'd0);
    chk("reset_bid", 64'(BID), 64'd0);
    chk("reset_bresp", 64'(BRESP), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge AClk); #1;
    ARst = 1'b1;
    WVALID = 1'b1;
    @(negedge AClk);
    chk("awready_before_first_edge", 64'(AWREADY), 64'd0);
    chk("early_wvalid_held_off", 64'(WREADY), 64'd0);
    @(posedge AClk); #1;
    chk("awready_after_first_edge", 64'(AWREADY), 64'd1);
    chk("idle_wready", 64'(WREADY), 64'd0);
    WVALID = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].burst, vecs[i].addr, vecs[i].len, vecs[i].size, 8'(8'h10 + i), 8'(8'h10 + i),
             -1, vecs[i].rdy_mode, 0, -1);
      chk($sformatf("vec%0d_beats", i), 64'(obs_addr.size()), 64'(int'(vecs[i].len) + 1));
      for (int b = 0; b < obs_addr.size() && b < 4; b++) begin
        if (vecs[i].exp_we) chk($sformatf("vec%0d_addr%0d", i, b), 64'(obs_addr[b]), 64'(vecs[i].exp_addr[b]));
        chk($sformatf("vec%0d_we%0d", i, b), 64'(obs_we[b]), 64'(vecs[i].exp_we));
      end
      chk($sformatf("vec%0d_bresp", i), 64'(obs_resp), 64'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_bid", i), 64'(obs_bid), 64'(8'h10 + i));
    end

    // WLAST on the second of four beats, BREADY held low for 5 cycles.
    do_txn(2'b01, 32'h400, 8'd3, 3'd3, 8'hA5, 8'hA5, 1, 0, 5, -1);
    chk("wlast_err_beats", 64'(obs_addr.size()), 64'd4);
    if (obs_we.size() == 4) begin
      chk("wlast_err_we0", 64'(obs_we[0]), 64'd1);
      chk("wlast_err_we3", 64'(obs_we[3]), 64'd0);
    end
    chk("wlast_err_bresp", 64'(obs_resp), 64'd2);
    chk("wlast_err_bid", 64'(obs_bid), 64'hA5);

    // Reset during the third beat, then a clean transaction.
    do_txn(2'b01, 32'h200, 8'd3, 3'd3, 8'h5A, 8'h5A, -1, 0, 0, 2);
    do_txn(2'b01, 32'h300, 8'd1, 3'd3, 8'h66, 8'h66, -1, 0, 0, -1);
    chk("post_reset_beats", 64'(obs_addr.size()), 64'd2);
    chk("post_reset_bresp", 64'(obs_resp), 64'd0);
    chk("post_reset_bid", 64'(obs_bid), 64'h66);
    if (obs_addr.size() == 2) chk("post_reset_addr1", 64'(obs_addr[1]), 64'h308);

    // WID differing from AWID.
    do_txn(2'b01, 32'h500, 8'd1, 3'd3, 8'h21, 8'h22, -1, 0, 0, -1);
`ifdef AXI_SLV_WID_CHECK_EN
    chk("wid_mismatch_bresp", 64'(obs_resp), 64'd2);
    if (obs_we.size() == 2) chk("wid_mismatch_we0", 64'(obs_we[0]), 64'd0);
`else
    chk("wid_ignored_bresp", 64'(obs_resp), 64'd0);
    if (obs_we.size() == 2) chk("wid_ignored_we0", 64'(obs_we[0]), 64'd1);
`endif

    // Randomized bursts against the model.
    wid_err = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) r_burst = 2'b11;
      else r_burst = 2'($urandom_range(0, 2));
      if (r_burst == 2'b10 && $urandom_range(0, 3) != 0) r_len = 8'(wrap_lens[$urandom_range(0, 3)]);
      else r_len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) r_size = 3'($urandom_range(0, 3));
      else r_size = 3'($urandom_range(4, 7));
      r_addr = $urandom();
      r_id   = 8'($urandom());
      r_bad  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
      r_dec  = model_dec_err(r_burst, r_len, r_size);
      do_txn(r_burst, r_addr, r_len, r_size, r_id, r_id, r_bad, 2, int'($urandom_range(0, 3)), -1);
      chk($sformatf("rnd%0d_beats", t), 64'(obs_addr.size()), 64'(int'(r_len) + 1));
      for (int b = 0; b < obs_addr.size(); b++) begin
        if (!r_dec)
          chk($sformatf("rnd%0d_addr%0d", t, b), 64'(obs_addr[b]), 64'(model_addr(r_burst, r_addr, r_len, r_size, b)));
        chk($sformatf("rnd%0d_we%0d", t, b), 64'(obs_we[b]),
            64'(!r_dec && !wid_err && !(r_bad >= 0 && b >= r_bad)));
      end
      chk($sformatf("rnd%0d_bresp", t), 64'(obs_resp), (r_dec || r_bad >= 0) ? 64'd2 : 64'd0);
      chk($sformatf("rnd%0d_bid", t), 64'(obs_bid), 64'(r_id));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
